// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: PC/word types, reset PC, fetch FSM states
// and the fetch-to-decode payload bundle.
package fetch_unit_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PCINIT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic valid;
    u64   pc;
    u32   raw_instr;
  } fetch_data_t;

  // Sequential next fetch address; wraps modulo 2^64.
  function automatic u64 next_pc(input u64 pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch unit: PC generation, instruction-bus handshake and fetch payload.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter u64 RESET_PC = PCINIT,
  parameter int INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ireq_valid,
  output logic [63:0]        ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  input  logic               f_accept,
  output logic               out_valid,
  output logic [63:0]        out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]        perf_fetched,
  output logic [63:0]        perf_stall
`endif
);

  fetch_state_t       state_r;
  u64                 pc_r;
  u64                 pend_pc_r;
  logic [INSTR_W-1:0] buf_instr_r;

  // Bus request and payload decode; REQ passes the bus response straight through.
  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = pc_r;
    out_valid  = 1'b0;
    out_pc     = pc_r;
    out_instr  = buf_instr_r;
    if (reset) begin
      out_pc    = 64'd0;
      out_instr = {INSTR_W{1'b0}};
    end else begin
      case (state_r)
        REQ: begin
          ireq_valid = 1'b1;
          out_valid  = iresp_data_ok & ~redirect_valid;
          out_instr  = iresp_data;
        end
        HOLD: begin
          out_valid = ~redirect_valid;
        end
        DISCARD: begin
          ireq_valid = 1'b1;
          out_instr  = {INSTR_W{1'b0}};
        end
        default: begin
          out_instr = {INSTR_W{1'b0}};
        end
      endcase
    end
    fetch_busy = ~out_valid;
  end

  // FSM and PC state; the request address (pc_r) only moves on a response or from HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= REQ;
      pc_r        <= RESET_PC;
      pend_pc_r   <= 64'd0;
      buf_instr_r <= {INSTR_W{1'b0}};
    end else begin
      case (state_r)
        REQ: begin
          if (iresp_data_ok) begin
            if (redirect_valid) begin
              pc_r <= redirect_pc;
            end else if (f_accept) begin
              pc_r <= next_pc(pc_r);
            end else begin
              buf_instr_r <= iresp_data;
              state_r     <= HOLD;
            end
          end else if (redirect_valid) begin
            pend_pc_r <= redirect_pc;
            state_r   <= DISCARD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_r    <= redirect_pc;
            state_r <= REQ;
          end else if (f_accept) begin
            pc_r    <= next_pc(pc_r);
            state_r <= REQ;
          end
        end
        DISCARD: begin
          // Newest redirect wins, including one arriving with the stale response.
          if (iresp_data_ok) begin
            pc_r    <= redirect_valid ? redirect_pc : pend_pc_r;
            state_r <= REQ;
          end else if (redirect_valid) begin
            pend_pc_r <= redirect_pc;
          end
        end
        default: begin
          state_r <= REQ;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Wrapping counters for delivered instructions and bus wait cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 64'd0;
      perf_stall   <= 64'd0;
    end else begin
      if (out_valid && f_accept) begin
        perf_fetched <= perf_fetched + 64'd1;
      end
      if (ireq_valid && !iresp_data_ok) begin
        perf_stall <= perf_stall + 64'd1;
      end
    end
  end
`endif

endmodule
